axi_lite_cmd_master: RTL and testbench
======================================

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, data width; legal values are 32 and 64.
REQ-003 SHALL have ports `clk` (input, 1, sole clock) and `reset` (input, 1, synchronous active-high).
REQ-004 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write, 0=read); cmd_addr in ADDR_WIDTH; cmd_wdata in BUS_WIDTH; cmd_wstrb in BUS_WIDTH/8.
REQ-005 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_write out 1; rsp_rdata out BUS_WIDTH; rsp_resp out 2.
REQ-006 SHALL have AXI-Lite write master ports: m_axi_awvalid out 1; m_axi_awready in 1; m_axi_awaddr out ADDR_WIDTH; m_axi_awprot out 3; m_axi_wvalid out 1; m_axi_wready in 1; m_axi_wdata out BUS_WIDTH; m_axi_wstrb out BUS_WIDTH/8; m_axi_bvalid in 1; m_axi_bready out 1; m_axi_bresp in 2.
REQ-007 SHALL have AXI-Lite read master ports: m_axi_arvalid out 1; m_axi_arready in 1; m_axi_araddr out ADDR_WIDTH; m_axi_rvalid in 1; m_axi_rready out 1; m_axi_rdata in BUS_WIDTH; m_axi_rresp in 2.

Function
REQ-008 SHALL keep at most one transaction outstanding; FSM states are IDLE, WR, WR_RESP, RD_ADDR, RD_DATA and RSP.
REQ-009 SHALL drive cmd_ready=1 only in IDLE; a command is accepted when cmd_valid&&cmd_ready; cmd_addr, cmd_wdata and cmd_wstrb SHALL be registered on acceptance.
REQ-010 SHALL, on acceptance in IDLE: go to WR if cmd_write=1, else RD_ADDR; m_axi valids SHALL assert the cycle after acceptance.
REQ-011 SHALL, in WR, assert awvalid and wvalid together at entry and drop each independently the cycle after its own handshake.
REQ-012 SHALL, in WR, leave for WR_RESP once both handshakes are done (same cycle or different cycles, in either order).
REQ-013 SHALL keep awaddr, wdata and wstrb stable while the corresponding valid is high.
REQ-014 SHALL, in WR_RESP, drive bready=1; on bvalid it SHALL capture bresp, set rsp_rdata=0 and rsp_write=1, then go to RSP.
REQ-015 SHALL, in RD_ADDR, drive arvalid=1 with the registered address; on arready it SHALL go to RD_DATA.
REQ-016 SHALL, in RD_DATA, drive rready=1; on rvalid it SHALL capture rdata and rresp, set rsp_write=0, then go to RSP.
REQ-017 SHALL, in RSP, hold rsp_valid=1 with stable rsp_* until rsp_ready; it SHALL then return to IDLE, and a new command SHALL NOT be accepted in that same cycle.
REQ-018 SHALL pass SLVERR and DECERR responses to rsp_resp unchanged and SHALL NOT retry.
REQ-019 SHALL drive m_axi_awprot to 3'b000 at all times.
REQ-020 SHALL deassert bready outside WR_RESP and rready outside RD_DATA; bvalid and rvalid arriving in other states SHALL be ignored.
REQ-021 SHALL give a minimum command-to-rsp_valid latency of 3 cycles for a zero-wait slave: accept, address/data handshake, response handshake.

Reset
REQ-022 SHALL, on reset, force IDLE and drive cmd_ready=1 and rsp_valid=0.
REQ-023 SHALL, on reset, drive all m_axi valids and readies to 0 and all m_axi address, data and strobe outputs to 0.
REQ-024 SHALL drive rsp_rdata, rsp_resp and rsp_write to 0 on reset.
REQ-025 SHALL abandon any in-flight transaction when reset is asserted mid-operation; the AXI slave SHALL share the same reset.

Configuration
REQ-026 SHALL, when AXI_LITE_CMD_MASTER_CNT_EN is defined, add outputs wr_count[15:0], rd_count[15:0] and err_count[15:0].
REQ-027 SHALL increment wr_count and rd_count by one per completed B or R handshake, and err_count by one on any non-OKAY response.
REQ-028 SHALL saturate all three counters at 16'hFFFF and clear them on reset.
REQ-029 SHALL, when AXI_LITE_CMD_MASTER_CNT_EN is undefined, omit the counter ports and logic, leaving behaviour otherwise identical.

Verification
REQ-030 SHALL cover: write 0x4, data 0xDEADBEEF, strb 0xF, zero-wait slave -> one aw/w beat each, rsp_valid at cycle 3, rsp_resp=00, rsp_write=1.
REQ-031 SHALL cover: write where awready comes 3 cycles after wready -> awvalid held with stable address, wvalid dropped after its beat, exactly one B accepted.
REQ-032 SHALL cover: read 0x4 with slave rdata=0x12345678 -> rsp_rdata=0x12345678, rsp_resp=00; read 0x100 -> rsp_resp=10 (SLVERR), rsp_rdata as returned.
REQ-033 SHALL cover: rsp_ready held low for 5 cycles -> rsp_* stable, cmd_ready=0 throughout, no new AXI activity.
REQ-034 SHALL cover: reset asserted during WR_RESP -> next cycle IDLE, all m_axi valids 0, rsp_valid=0, cmd_ready=1.
REQ-035 SHALL cover, with AXI_LITE_CMD_MASTER_CNT_EN defined: 2 writes and 1 SLVERR read -> wr_count=2, rd_count=1, err_count=1.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a simple valid/ready command/response pair.
// Optional transaction counters are enabled with `define AXI_LITE_CMD_MASTER_CNT_EN.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  // command side
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [BUS_WIDTH-1:0]    cmd_wdata,
  input  logic [BUS_WIDTH/8-1:0]  cmd_wstrb,
  // response side
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [BUS_WIDTH-1:0]    rsp_rdata,
  output logic [1:0]              rsp_resp,
  // AXI-Lite write channels
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [BUS_WIDTH-1:0]    m_axi_wdata,
  output logic [BUS_WIDTH/8-1:0]  m_axi_wstrb,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  // AXI-Lite read channels
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic [BUS_WIDTH-1:0]    m_axi_rdata,
  input  logic [1:0]              m_axi_rresp
`ifdef AXI_LITE_CMD_MASTER_CNT_EN
  ,
  output logic [15:0]             wr_count,
  output logic [15:0]             rd_count,
  output logic [15:0]             err_count
`endif
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BUS_WIDTH-1:0]    wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    aw_done, w_done;
  logic [BUS_WIDTH-1:0]    rsp_rdata_q;
  logic [1:0]              rsp_resp_q;
  logic                    rsp_write_q;

  logic cmd_accept, aw_hs, w_hs, b_hs, r_hs;

  assign cmd_accept = cmd_valid && cmd_ready;
  assign aw_hs      = m_axi_awvalid && m_axi_awready;
  assign w_hs       = m_axi_wvalid && m_axi_wready;
  assign b_hs       = m_axi_bvalid && m_axi_bready;
  assign r_hs       = m_axi_rvalid && m_axi_rready;

  // Address/data come straight from the registered command so they cannot move under a valid.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = 3'b000;

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_write = rsp_write_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = cmd_write ? WR : RD_ADDR;
      end
      WR: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        // Each channel is finished either by an earlier beat or by one happening now.
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_next = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_next = RSP;
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_next = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all datapath registers are reset because their values are visible on ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      rsp_write_q <= 1'b0;
    end else begin
      if (cmd_accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs) begin
        rsp_rdata_q <= '0;
        rsp_resp_q  <= m_axi_bresp;
        rsp_write_q <= 1'b1;
      end
      if (r_hs) begin
        rsp_rdata_q <= m_axi_rdata;
        rsp_resp_q  <= m_axi_rresp;
        rsp_write_q <= 1'b0;
      end
    end
  end

`ifdef AXI_LITE_CMD_MASTER_CNT_EN
  // Saturating completion and error counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count  <= 16'd0;
      rd_count  <= 16'd0;
      err_count <= 16'd0;
    end else begin
      if (b_hs && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (r_hs && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (((b_hs && m_axi_bresp != 2'b00) || (r_hs && m_axi_rresp != 2'b00))
          && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed testbench for axi_lite_cmd_master; the AXI slave is played cycle by cycle.
// Counter checks are compiled in when AXI_LITE_CMD_MASTER_CNT_EN is defined.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
`ifdef AXI_LITE_CMD_MASTER_CNT_EN
  logic [15:0] wr_count, rd_count, err_count;
`endif

  int tests = 0;
  int fails = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw0, w0, b0, ar0, r0;

  axi_lite_cmd_master #(.ADDR_WIDTH(32), .BUS_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
`ifdef AXI_LITE_CMD_MASTER_CNT_EN
    , .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // Handshake monitor: values are stable mid-cycle, the beat lands on the next rising edge.
  always @(negedge clk) begin
    if (m_axi_awvalid && m_axi_awready) aw_cnt++;
    if (m_axi_wvalid && m_axi_wready)   w_cnt++;
    if (m_axi_bvalid && m_axi_bready)   b_cnt++;
    if (m_axi_arvalid && m_axi_arready) ar_cnt++;
    if (m_axi_rvalid && m_axi_rready)   r_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
  endtask

  // Zero-wait write: accept, aw/w beat, B beat, response.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] bresp);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    send_cmd(1'b1, addr, data, 4'hF);
    tick;
    cmd_valid = 1'b0;
    check("wr_awaddr", m_axi_awaddr, addr);
    tick;
    m_axi_bvalid = 1'b1; m_axi_bresp = bresp;
    tick;
    m_axi_bvalid = 1'b0;
    check("wr_rsp_valid", rsp_valid, 1'b1);
    check("wr_rsp_resp", rsp_resp, bresp);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  // Zero-wait read: accept, ar beat, R beat, response.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] rresp);
    m_axi_arready = 1'b1;
    send_cmd(1'b0, addr, 32'h0, 4'h0);
    tick;
    cmd_valid = 1'b0;
    check("rd_araddr", m_axi_araddr, addr);
    tick;
    m_axi_rvalid = 1'b1; m_axi_rdata = data; m_axi_rresp = rresp;
    tick;
    m_axi_rvalid = 1'b0;
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp_rdata", rsp_rdata, data);
    check("rd_rsp_resp", rsp_resp, rresp);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    tick;
    tick;

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 3'b000);
    check("rst_readies", {m_axi_bready, m_axi_rready}, 2'b00);
    check("rst_addr_data", {m_axi_awaddr, m_axi_wdata}, 64'h0);
    check("rst_rsp_fields", {rsp_rdata, rsp_resp, rsp_write}, 35'h0);
    reset = 1'b0;

    // Zero-wait write 0x4 / 0xDEADBEEF: rsp_valid three cycles after acceptance
    snap;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    send_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    tick;
    cmd_valid = 1'b0;
    check("w1_c1_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    check("w1_c1_cmd_ready", cmd_ready, 1'b0);
    check("w1_c1_awaddr", m_axi_awaddr, 32'h4);
    check("w1_c1_wdata", m_axi_wdata, 32'hDEADBEEF);
    check("w1_c1_wstrb", m_axi_wstrb, 4'hF);
    check("w1_awprot", m_axi_awprot, 3'b000);
    tick;
    check("w1_c2_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
    check("w1_c2_bready", m_axi_bready, 1'b1);
    check("w1_c2_rsp_valid", rsp_valid, 1'b0);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
    tick;
    m_axi_bvalid = 1'b0;
    check("w1_c3_rsp_valid", rsp_valid, 1'b1);
    check("w1_c3_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
    check("w1_c3_bready", m_axi_bready, 1'b0);
    check("w1_beats", {aw_cnt - aw0, w_cnt - w0, b_cnt - b0}, {32'd1, 32'd1, 32'd1});
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("w1_back_idle", {cmd_ready, rsp_valid}, 2'b10);

    // Write where awready arrives three cycles after the W beat; early bvalid must be ignored
    snap;
    m_axi_awready = 1'b0; m_axi_wready = 1'b1;
    send_cmd(1'b1, 32'h8, 32'hA5A50001, 4'h3);
    tick;
    cmd_valid = 1'b0;
    check("w2_c1_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    tick;
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
    for (int i = 0; i < 3; i++) begin
      check("w2_aw_held", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
      check("w2_aw_addr", m_axi_awaddr, 32'h8);
      check("w2_no_bready", m_axi_bready, 1'b0);
      if (i == 2) m_axi_awready = 1'b1;
      tick;
    end
    check("w2_resp_state", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
    tick;
    m_axi_bvalid = 1'b0;
    check("w2_rsp", {rsp_valid, rsp_write, rsp_resp}, 4'b1100);
    check("w2_beats", {aw_cnt - aw0, w_cnt - w0, b_cnt - b0}, {32'd1, 32'd1, 32'd1});
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    // Read 0x4, then a five-cycle rsp_ready stall with a pending command and a stray rvalid
    snap;
    m_axi_arready = 1'b1;
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    tick;
    cmd_valid = 1'b0;
    check("r1_c1_arvalid", {m_axi_arvalid, m_axi_rready}, 2'b10);
    check("r1_c1_araddr", m_axi_araddr, 32'h4);
    tick;
    check("r1_c2_rready", {m_axi_arvalid, m_axi_rready}, 2'b01);
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h12345678; m_axi_rresp = 2'b00;
    tick;
    send_cmd(1'b0, 32'h100, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'h12345678});
      check("stall_cmd_ready", cmd_ready, 1'b0);
      check("stall_axi", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 5'b0);
      tick;
    end
    check("stall_beats", {ar_cnt - ar0, r_cnt - r0}, {32'd1, 32'd1});
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    m_axi_rvalid = 1'b0;
    check("rsp_exit_idle", {cmd_ready, rsp_valid, m_axi_arvalid}, 3'b100);
    tick;
    cmd_valid = 1'b0;
    check("r2_c1_araddr", {m_axi_arvalid, m_axi_araddr}, {1'b1, 32'h100});
    tick;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hDEAD0100; m_axi_rresp = 2'b10;
    tick;
    m_axi_rvalid = 1'b0;
    check("r2_slverr", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b10, 32'hDEAD0100});
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
`ifdef AXI_LITE_CMD_MASTER_CNT_EN
    check("cnt_before_reset", {wr_count, rd_count, err_count}, {16'd2, 16'd2, 16'd1});
`endif

    // Reset while waiting in WR_RESP
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    send_cmd(1'b1, 32'hC, 32'h0BADF00D, 4'hF);
    tick;
    cmd_valid = 1'b0;
    tick;
    check("rst_mid_bready", m_axi_bready, 1'b1);
    reset = 1'b1;
    tick;
    check("rst_mid_cmd_ready", {cmd_ready, rsp_valid}, 2'b10);
    check("rst_mid_axi", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 5'b0);
    check("rst_mid_addr", m_axi_awaddr, 32'h0);
`ifdef AXI_LITE_CMD_MASTER_CNT_EN
    check("cnt_after_reset", {wr_count, rd_count, err_count}, 48'h0);
`endif
    reset = 1'b0;

    // Two writes and one SLVERR read after reset
    do_write(32'h10, 32'h11111111, 2'b00);
    do_write(32'h14, 32'h22222222, 2'b00);
    do_read(32'h100, 32'hCAFE0001, 2'b10);
`ifdef AXI_LITE_CMD_MASTER_CNT_EN
    check("cnt_final", {wr_count, rd_count, err_count}, {16'd2, 16'd1, 16'd1});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
